// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: bus geometry
// defaults, FSM state encoding and the operation type.
package data_mem_responder_pkg;

    localparam int DMR_WORD_WIDTH = 32;
    localparam int DMR_ADDR_BASE  = 1024;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/dmr_word_array.sv
// Word array behind the responder: synchronous write, registered read.
// The read register can also be forced to zero for out-of-range accesses.
module dmr_word_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic             i_clr,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Commit a write into the array on the completing edge.
    // NOTE: the storage array has no reset; clearing it would turn a RAM into a register file, and the contents are allowed to survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Registered read port; reset and out-of-range completions return zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the MEM-stage data-memory interface. Accepts a read or write,
// waits WAIT_CYCLES edges, completes against the word array, pulses ready for
// one cycle and holds freeze high while the access is outstanding.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WORD_WIDTH  = DMR_WORD_WIDTH,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_BASE   = DMR_ADDR_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  freeze
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    op_t                   r_op;
    logic                  r_err;

    logic                  w_req;
    logic                  w_last;
    logic [WORD_WIDTH-1:0] w_offset;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_we;
    logic                  w_re;
    logic                  w_clr;

    assign w_req  = mem_read | mem_write;
    assign w_last = (r_state == S_WAIT) && (r_count == '0);

    // Address decode on the latched address; low two bits select a byte and are dropped.
    assign w_offset   = r_addr - WORD_WIDTH'(ADDR_BASE);
    assign w_in_range = (r_addr >= WORD_WIDTH'(ADDR_BASE)) &&
                        ((w_offset >> 2) < WORD_WIDTH'(DEPTH));
    assign w_idx      = w_offset[IDX_W+1:2];

    // Array strobes fire only on the completing edge.
    assign w_we  = w_last && (r_op == OP_WRITE) && w_in_range;
    assign w_re  = w_last && (r_op == OP_READ)  && w_in_range;
    assign w_clr = w_last && !w_in_range;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output of this block is given a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                ready        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        freeze = w_req & ~ready;
    end

    // Request capture and wait-state counter; inputs are ignored once latched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_READ;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_count <= CNT_W'(WAIT_CYCLES - 1);
            r_addr  <= addr;
            r_wdata <= wdata;
            r_op    <= mem_write ? OP_WRITE : OP_READ;
        end else if ((r_state == S_WAIT) && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Error flag: set on an out-of-range completion, cleared when DONE retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_last) begin
            r_err <= !w_in_range;
        end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;

    dmr_word_array #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_word_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=3 and 1) driven with
// directed and random accesses. Expected responses come from a word-array model
// and are queued at issue time; a monitor pops them whenever ready is seen.
module tb_data_mem_responder;

    localparam int BASE  = 1024;
    localparam int DEPTH = 64;

    typedef struct {
        bit          is_read;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_s;
    logic [1:0]  wr_s;
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic [1:0]  ready_s;
    logic [1:0]  err_s;
    logic [1:0]  freeze_s;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mm    [2][DEPTH];
    bit          known [2][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
        .ready(ready_s[0]), .err(err_s[0]), .freeze(freeze_s[0])
    );

    data_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
        .ready(ready_s[1]), .err(err_s[1]), .freeze(freeze_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    // Issue one access (called at a negedge) and wait for its ready pulse.
    // chained=1 means the request was raised during the previous DONE cycle.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd, input bit chained);
        exp_t e;
        int   n   = 0;
        int   fz  = 0;
        bit   got = 0;
        bit   inr;
        int   idx;
        inr = (a >= BASE) && ((a - BASE) / 4 < DEPTH);
        idx = inr ? int'((a - BASE) / 4) : 0;
        e.is_read = !wr;
        e.err     = !inr;
        e.data    = (inr && !wr) ? mm[d][idx] : 32'h0;
        if (wr && inr) begin
            mm[d][idx]    = wd;
            known[d][idx] = 1'b1;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        rd_s[d]    = rd;
        wr_s[d]    = wr;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready_s[d]) got = 1'b1;
            else if (freeze_s[d]) fz++;
            if (!got && n == 1 + int'(chained)) begin
                addr_s[d]  = $urandom;
                wdata_s[d] = $urandom;
            end
        end
        check($sformatf("ready_seen d%0d", d), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("latency d%0d a=%h", d, a), n, wait_of(d) + 1 + int'(chained));
            check($sformatf("freeze_cycles d%0d a=%h", d, a), fz, wait_of(d) + int'(chained));
        end
    endtask

    task automatic idle(input int d);
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor: one expectation per ready pulse, in issue order.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (ready_s[d]) begin
                    exp_t e;
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("unexpected_ready d%0d", d), 32'd1, 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("err d%0d", d), 32'(err_s[d]), 32'(e.err));
                        if (e.is_read || e.err) begin
                            check($sformatf("rdata d%0d", d), rdata_s[d], e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst  = 1'b0;
        rd_s = '0;
        wr_s = '0;
        for (int d = 0; d < 2; d++) begin
            addr_s[d]  = '0;
            wdata_s[d] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                known[d][i] = 1'b0;
                mm[d][i]    = '0;
            end
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready d%0d", d), 32'(ready_s[d]), 32'd0);
            check($sformatf("reset_err d%0d", d), 32'(err_s[d]), 32'd0);
            check($sformatf("reset_rdata d%0d", d), rdata_s[d], 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Basic write then read, first and last words, out-of-range both sides.
        access(0, 0, 1, 32'd1024, 32'hDEADBEEF, 0); idle(0);
        access(0, 1, 0, 32'd1024, 32'h0, 0);        idle(0);
        access(0, 0, 1, 32'd1276, 32'hCAFE0063, 0); idle(0);
        access(0, 1, 0, 32'd1276, 32'h0, 0);        idle(0);
        access(0, 1, 0, 32'd1280, 32'h0, 0);        idle(0);
        access(0, 0, 1, 32'd1280, 32'h12345678, 0); idle(0);
        access(0, 1, 0, 32'd1276, 32'h0, 0);        idle(0);
        access(0, 1, 0, 32'd1020, 32'h0, 0);        idle(0);
        access(0, 1, 0, 32'd1027, 32'h0, 0);        idle(0);
        // Both requests high is a write.
        access(0, 1, 1, 32'd1032, 32'h00000077, 0); idle(0);
        access(0, 1, 0, 32'd1032, 32'h0, 0);        idle(0);

        // Reset during WAIT abandons the pending write.
        access(0, 0, 1, 32'd1028, 32'h00000011, 0); idle(0);
        wr_s[0] = 1'b1; addr_s[0] = 32'd1028; wdata_s[0] = 32'h00000055;
        repeat (2) @(negedge clk);
        check("freeze_before_reset", 32'(freeze_s[0]), 32'd1);
        rst     = 1'b0;
        wr_s[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_in_reset", 32'(ready_s[0]), 32'd0);
        end
        check("rdata_after_reset", rdata_s[0], 32'd0);
        rst = 1'b1;
        @(negedge clk);
        access(0, 1, 0, 32'd1028, 32'h0, 0); idle(0);

        // Single wait state: back-to-back reads complete in order.
        access(1, 0, 1, 32'd1024, 32'hA0A0A0A0, 0); idle(1);
        access(1, 0, 1, 32'd1028, 32'hB1B1B1B1, 0); idle(1);
        access(1, 1, 0, 32'd1024, 32'h0, 0);
        access(1, 1, 0, 32'd1028, 32'h0, 1);        idle(1);

        // Random traffic on both instances, sometimes with a held request.
        for (int d = 0; d < 2; d++) begin
            bit chain = 1'b0;
            for (int i = 0; i < 40; i++) begin
                int          kind;
                int          wi;
                logic [31:0] a;
                bit          w;
                kind = int'($urandom_range(0, 7));
                wi   = int'($urandom_range(0, DEPTH - 1));
                if (kind < 6)       a = BASE + 4 * wi + $urandom_range(0, 3);
                else if (kind == 6) a = $urandom_range(0, BASE - 1);
                else                a = BASE + 4 * DEPTH + $urandom_range(0, 4095);
                w = ($urandom_range(0, 1) == 1) || (kind < 6 && !known[d][wi]);
                access(d, !w, w, a, $urandom, chain);
                chain = ($urandom_range(0, 2) == 0);
                if (!chain) idle(d);
            end
            idle(d);
        end

        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
